gate_identifier: RTL
====================

# gate_identifier

Sequential truth-table sweeper that identifies an unknown 2-input logic function, such as a mux-built AND/OR/NAND/NOR/XOR/XNOR cell.
- On `start` it drives all four input combinations onto `probe_a`/`probe_b` and samples the device-under-test output `dut_y` after a settle delay.
- It assembles a 4-bit truth table and decodes it into a gate code.
- It sits in the gate-lab test harness as the checker for mux-implemented gate cells.

## Interface
- `SETTLE_CYCLES`, default 1: cycles each probe vector is held before `dut_y` is sampled; legal range 1..15.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `start`  in  1  request a sweep; sampled only in IDLE.
- `dut_y`  in  1  output of the gate under test.
- `probe_a`  out  1  input a driven to the gate under test.
- `probe_b`  out  1  input b driven to the gate under test.
- `busy`  out  1  high while a sweep is in progress (APPLY or DECODE).
- `done`  out  1  one-cycle pulse when results update.
- `truth_table`  out  4  bit index {a,b} holds the captured y; held until the next `done`.
- `gate_code`  out  4  classification; held until the next `done`.

## Operation
- Gate codes:
  - 0 AND (tt 4'b1000)
  - 1 OR (4'b1110)
  - 2 NAND (4'b0111)
  - 3 NOR (4'b0001)
  - 4 XOR (4'b0110)
  - 5 XNOR (4'b1001)
  - 6 CONST0 (4'b0000)
  - 7 CONST1 (4'b1111)
  - 15 UNKNOWN
- FSM states:
  - IDLE: probes 0, `busy` 0. `start`=1 → APPLY with idx=0 and cnt=0.
  - APPLY: `{probe_a,probe_b}` = idx. cnt increments each cycle. On the cycle where cnt==SETTLE_CYCLES-1, tt[idx] is captured from `dut_y` and cnt clears. If idx==3 → DECODE, else idx+1.
  - DECODE: one cycle; `truth_table` and `gate_code` are registered at the exit edge, `done` pulses in the following cycle, → IDLE.
- `start` during APPLY/DECODE is ignored, not queued.
- The internal capture register is cleared on entry to APPLY, so stale bits never leak between sweeps.
- Reset values: `probe_a`=0, `probe_b`=0, `busy`=0, `done`=0, `truth_table`=4'b0000, `gate_code`=15, FSM=IDLE, idx=0, cnt=0.
- Reset mid-sweep aborts immediately: outputs return to their reset values, no `done` pulse occurs, and the partial table is discarded.

## Timing
- `start` sampled at edge E0 → probes show vector 0 from E0. `dut_y` is sampled at edge E0+S for vector 0, E0+2S for vector 1, and so on (S=SETTLE_CYCLES).
- DECODE is the cycle after the fourth sample.
- `done` is high in the cycle after DECODE, i.e. the cycle beginning at edge E0+4S+1. The new `gate_code`/`truth_table` are visible in that same cycle.
- `busy` rises at E0 and falls at E0+4S+1, coinciding with `done` rising.
- `start` is honoured again in the `done` cycle (IDLE); back-to-back sweeps are legal.
- `dut_y` is treated as combinational from the probes and must be stable within S cycles.

## Configuration
- `GATE_ID_CONST_EN` defined:
  - tt 4'b0000 → 6 (CONST0).
  - tt 4'b1111 → 7 (CONST1).
- `GATE_ID_CONST_EN` undefined:
  - both constant tables → 15 (UNKNOWN).
  - codes 6/7 are never produced.
- The remaining decode is identical in both builds.

## Structure
- Package `gate_id_pkg`:
  - gate-code localparams (CODE_AND..CODE_UNKNOWN).
  - FSM state encodings (IDLE, APPLY, DECODE).
  - the tt constant for each gate.
- Sub-module `gate_code_decoder`: purely combinational, 4-bit tt → 4-bit code. It contains the `GATE_ID_CONST_EN` guard.
- The top level holds the FSM, idx/cnt counters, capture register and output registers.

## Test plan
- S=1, `dut_y`=`probe_a & probe_b`, pulse `start` → `done` 5 cycles after the `start` edge, tt=4'b1000, code=0, `busy` high for exactly 5 cycles.
- S=1, loop through OR/NAND/NOR/XOR/XNOR back-to-back, re-asserting `start` in each `done` cycle → codes 1,2,3,4,5 with tt 1110,0111,0001,0110,1001.
- `dut_y`=0 → without macro: tt 0000, code 15; with `GATE_ID_CONST_EN`: code 6. `dut_y`=1 → code 15 / code 7 respectively.
- `dut_y`=`probe_a` (tt 1100) → code 15 in both builds.
- S=3, XOR DUT → `done` at edge E0+13, code 4.
- Mid-sweep conditions, S=3, AND DUT:
  - assert `rst` at E0+5 → next cycle probes 0, `busy` 0, code 15, no `done`.
  - `start` held high during a sweep → exactly one `done` per sweep.

Source files
------------

// File: rtl/gate_id_pkg.sv
// rtl/gate_id_pkg.sv - shared gate codes, truth-table constants and FSM states
//
// Purpose: common definitions for gate_identifier and gate_code_decoder.
// Truth-table bit index is {a,b}; the bit holds the gate output y.
package gate_id_pkg;

  localparam logic [3:0] CODE_AND     = 4'd0;
  localparam logic [3:0] CODE_OR      = 4'd1;
  localparam logic [3:0] CODE_NAND    = 4'd2;
  localparam logic [3:0] CODE_NOR     = 4'd3;
  localparam logic [3:0] CODE_XOR     = 4'd4;
  localparam logic [3:0] CODE_XNOR    = 4'd5;
  localparam logic [3:0] CODE_CONST0  = 4'd6;
  localparam logic [3:0] CODE_CONST1  = 4'd7;
  localparam logic [3:0] CODE_UNKNOWN = 4'd15;

  localparam logic [3:0] TT_AND    = 4'b1000;
  localparam logic [3:0] TT_OR     = 4'b1110;
  localparam logic [3:0] TT_NAND   = 4'b0111;
  localparam logic [3:0] TT_NOR    = 4'b0001;
  localparam logic [3:0] TT_XOR    = 4'b0110;
  localparam logic [3:0] TT_XNOR   = 4'b1001;
  localparam logic [3:0] TT_CONST0 = 4'b0000;
  localparam logic [3:0] TT_CONST1 = 4'b1111;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    APPLY  = 2'd1,
    DECODE = 2'd2
  } state_t;

endpackage

// File: rtl/gate_code_decoder.sv
// rtl/gate_code_decoder.sv - combinational truth-table to gate-code classifier
//
// Ports:
//   tt    in  4  captured truth table, bit index {a,b}
//   code  out 4  gate code (CODE_* from gate_id_pkg), CODE_UNKNOWN if unmatched
// Build option: GATE_ID_CONST_EN enables CONST0/CONST1 classification;
// without it the constant tables fall through to CODE_UNKNOWN.
module gate_code_decoder
  import gate_id_pkg::*;
(
  input  logic [3:0] tt,
  output logic [3:0] code
);

  always_comb begin
    code = CODE_UNKNOWN;
    case (tt)
      TT_AND:    code = CODE_AND;
      TT_OR:     code = CODE_OR;
      TT_NAND:   code = CODE_NAND;
      TT_NOR:    code = CODE_NOR;
      TT_XOR:    code = CODE_XOR;
      TT_XNOR:   code = CODE_XNOR;
`ifdef GATE_ID_CONST_EN
      TT_CONST0: code = CODE_CONST0;
      TT_CONST1: code = CODE_CONST1;
`else
      TT_CONST0: code = CODE_UNKNOWN;
      TT_CONST1: code = CODE_UNKNOWN;
`endif
      default:   code = CODE_UNKNOWN;
    endcase
  end

endmodule

// File: rtl/gate_identifier.sv
// rtl/gate_identifier.sv - truth-table sweeper identifying a 2-input gate
//
// Parameters:
//   SETTLE_CYCLES  cycles each probe vector is held before dut_y is sampled (1..15)
// Ports:
//   clk          in   1  clock, rising edge
//   rst          in   1  synchronous active-high reset
//   start        in   1  sweep request, honoured only in IDLE
//   dut_y        in   1  output of the gate under test
//   probe_a      out  1  gate input a
//   probe_b      out  1  gate input b
//   busy         out  1  sweep in progress (APPLY/DECODE)
//   done         out  1  one-cycle pulse when truth_table/gate_code update
//   truth_table  out  4  captured table, bit index {a,b}
//   gate_code    out  4  classification of truth_table
// Build option: GATE_ID_CONST_EN (handled in gate_code_decoder).
module gate_identifier
  import gate_id_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       dut_y,
  output logic       probe_a,
  output logic       probe_b,
  output logic       busy,
  output logic       done,
  output logic [3:0] truth_table,
  output logic [3:0] gate_code
);

  localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);

  state_t     state;
  logic [1:0] idx;
  logic [3:0] cnt;
  logic [3:0] tt_cap;
  logic [3:0] decoded;

  gate_code_decoder u_decoder (
    .tt   (tt_cap),
    .code (decoded)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= 2'd0;
      cnt         <= 4'd0;
      tt_cap      <= 4'd0;
      probe_a     <= 1'b0;
      probe_b     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      truth_table <= 4'd0;
      gate_code   <= CODE_UNKNOWN;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= APPLY;
            idx     <= 2'd0;
            cnt     <= 4'd0;
            tt_cap  <= 4'd0;  // no bits from a previous sweep survive
            probe_a <= 1'b0;
            probe_b <= 1'b0;
            busy    <= 1'b1;
          end
        end

        APPLY: begin
          // Probes are registered, so dut_y already reflects vector idx here.
          if (cnt == CNT_LAST) begin
            tt_cap[idx] <= dut_y;
            cnt         <= 4'd0;
            if (idx == 2'd3) begin
              state   <= DECODE;
              idx     <= 2'd0;
              probe_a <= 1'b0;
              probe_b <= 1'b0;
            end else begin
              idx                <= idx + 2'd1;
              {probe_a, probe_b} <= idx + 2'd1;
            end
          end else begin
            cnt <= cnt + 4'd1;
          end
        end

        DECODE: begin
          // Results and done land on the same edge so they appear together.
          truth_table <= tt_cap;
          gate_code   <= decoded;
          done        <= 1'b1;
          busy        <= 1'b0;
          state       <= IDLE;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
